// File: rtl/gamepad_scan_pkg.sv
// Shared definitions for the gamepad scanner.
//   state_t   : scan FSM state encoding
//   pad_count : number of pads addressed by DATA_WIDTH lines x 2**SEL_WIDTH groups
//   idx_width : read index width for a given pad count (never below 1)
package gamepad_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_LATCH,
    ST_LWAIT,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_COMMIT,
    ST_DONE
  } state_t;

  function automatic int pad_count(input int data_width, input int sel_width);
    return data_width << sel_width;
  endfunction

  function automatic int idx_width(input int npads);
    return (npads > 2) ? $clog2(npads) : 1;
  endfunction

endpackage

// File: rtl/gamepad_scan_tick.sv
// Phase tick divider for the gamepad scanner.
//   clk       : system clock
//   rst       : synchronous reset, active low
//   restart_i : reload the counter to DIV so the next phase is a full DIV+1 clk
//   tick_o    : high for one clk each time the counter reaches 0
// The counter free-runs DIV..0 and resets to 0, so the first tick after reset
// is immediate.
module gamepad_scan_tick #(
  parameter int DIV = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (restart_i || tick_o) cnt_d = CW'(DIV);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gamepad_scan.sv
// Autonomous multi-pad scanner for NES/SNES-style serial gamepads.
//   clk, rst            : system clock, synchronous active-low reset
//   gp_sel/gp_latch/gp_clk/gp_data : pad interface (data active low)
//   ctrl_go/ctrl_auto/ctrl_rdy     : one-shot start, periodic mode, idle flag
//   scan_done           : one-clk pulse after the last group is committed
//   rd_en/rd_idx        : registered read of pad word and change flag
//   rd_value/rd_chg     : read result, valid the clk after rd_en, held
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | ctrl_rdy=1, counting auto ticks when ctrl_auto=1
// ST_SEL    | gp_sel driven, pad group settling (1 tick)
// ST_LATCH  | gp_latch=1 (1 tick)
// ST_LWAIT  | gp_latch=0, first bit settling (1 tick)
// ST_CLK_LO | gp_clk=0, data sampled at the end (1 tick)
// ST_CLK_HI | gp_clk=1, pad shifts on the rising edge (1 tick)
// ST_COMMIT | shift registers copied to pad words (1 clk)
// ST_DONE   | scan_done=1 (1 clk)
module gamepad_scan
  import gamepad_scan_pkg::*;
#(
  parameter int DIV        = 15,
  parameter int SEL_WIDTH  = 1,
  parameter int DATA_WIDTH = 2,
  parameter int NBITS      = 16,
  parameter int AUTO_DIV   = 1000,
  localparam int NPADS     = pad_count(DATA_WIDTH, SEL_WIDTH),
  localparam int IW        = idx_width(NPADS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [SEL_WIDTH-1:0]  gp_sel,
  input  logic [DATA_WIDTH-1:0] gp_data,
  output logic                  gp_latch,
  output logic                  gp_clk,
  input  logic                  ctrl_go,
  input  logic                  ctrl_auto,
  output logic                  ctrl_rdy,
  output logic                  scan_done,
  input  logic                  rd_en,
  input  logic [IW-1:0]         rd_idx,
  output logic [NBITS-1:0]      rd_value,
  output logic                  rd_chg
);

  localparam int BW   = $clog2(NBITS + 1);
  localparam int AW   = $clog2(AUTO_DIV + 1);
  localparam int NGRP = 1 << SEL_WIDTH;

  state_t               state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [AW-1:0]        auto_q, auto_d;
  logic                 tick, restart;

  logic [NBITS-1:0]     shreg_q [DATA_WIDTH];
  logic [NBITS-1:0]     pad_q   [NPADS];
  logic                 chg_q   [NPADS];
  logic [NBITS-1:0]     rd_value_q;
  logic                 rd_chg_q;

  gamepad_scan_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    auto_d  = '0;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        auto_d = auto_q;
        if (!ctrl_auto) auto_d = '0;
        else if (tick)  auto_d = auto_q + 1'b1;
        // A go that coincides with auto expiry still yields a single scan.
        if (ctrl_go || (ctrl_auto && tick && auto_q == AW'(AUTO_DIV - 1))) begin
          state_d = ST_SEL;
          sel_d   = '0;
          auto_d  = '0;
          restart = 1'b1;
        end
      end
      ST_SEL:   if (tick) state_d = ST_LATCH;
      ST_LATCH: if (tick) state_d = ST_LWAIT;
      ST_LWAIT: if (tick) begin
        state_d = ST_CLK_LO;
        bit_d   = '0;
      end
      ST_CLK_LO: if (tick) state_d = ST_CLK_HI;
      ST_CLK_HI: if (tick) begin
        if (bit_q == BW'(NBITS - 1)) state_d = ST_COMMIT;
        else begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_CLK_LO;
        end
      end
      ST_COMMIT: begin
        // Wraps back to group 0 after the last group.
        sel_d = sel_q + 1'b1;
        if (sel_q == SEL_WIDTH'(NGRP - 1)) state_d = ST_DONE;
        else begin
          state_d = ST_SEL;
          restart = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      sel_q   <= '0;
      auto_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sel_q   <= sel_d;
      auto_q  <= auto_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < DATA_WIDTH; d++) shreg_q[d] <= '0;
    end else if (state_q == ST_CLK_LO && tick) begin
      for (int d = 0; d < DATA_WIDTH; d++)
        for (int k = 0; k < NBITS; k++)
          if (bit_q == BW'(k)) shreg_q[d][k] <= ~gp_data[d];
    end
  end

  // Read first, commit second: the read sees the pre-commit word and a commit
  // that sets a change flag overrides the read's clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NPADS; p++) begin
        pad_q[p] <= '0;
        chg_q[p] <= 1'b0;
      end
      rd_value_q <= '0;
      rd_chg_q   <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_value_q <= '0;
        rd_chg_q   <= 1'b0;
      end
      for (int p = 0; p < NPADS; p++) begin
        if (rd_en && rd_idx == IW'(p)) begin
          rd_value_q <= pad_q[p];
          rd_chg_q   <= chg_q[p];
          chg_q[p]   <= 1'b0;
        end
        if (state_q == ST_COMMIT && sel_q == SEL_WIDTH'(p / DATA_WIDTH)) begin
          pad_q[p] <= shreg_q[p % DATA_WIDTH];
          if (shreg_q[p % DATA_WIDTH] != pad_q[p]) chg_q[p] <= 1'b1;
        end
      end
    end
  end

  assign gp_sel    = sel_q;
  assign gp_latch  = (state_q == ST_LATCH);
  assign gp_clk    = (state_q != ST_CLK_LO);
  assign ctrl_rdy  = (state_q == ST_IDLE);
  assign scan_done = (state_q == ST_DONE);
  assign rd_value  = rd_value_q;
  assign rd_chg    = rd_chg_q;

endmodule

// File: tb/tb_gamepad_scan.sv
// Self-checking bench for gamepad_scan: behavioural pad model on the bus,
// a model of pad words / change flags, and a read scoreboard.
module tb_gamepad_scan;

  localparam int DIV      = 15;
  localparam int SW       = 1;
  localparam int DW       = 2;
  localparam int NB       = 16;
  localparam int AUTO_DIV = 4;
  localparam int NGRP     = 1 << SW;
  localparam int NPADS    = DW * NGRP;
  localparam int GRP_CLK  = (DIV + 1) * (3 + 2 * NB);
  localparam int SCAN_LAT = NGRP * GRP_CLK + NGRP;
  localparam int LIMIT    = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SW-1:0] gp_sel;
  logic [DW-1:0] gp_data;
  logic          gp_latch, gp_clk;
  logic          ctrl_go, ctrl_auto, ctrl_rdy, scan_done;
  logic          rd_en;
  logic [1:0]    rd_idx;
  logic [NB-1:0] rd_value;
  logic          rd_chg;

  always #5 clk = ~clk;

  gamepad_scan #(
    .DIV(DIV), .SEL_WIDTH(SW), .DATA_WIDTH(DW), .NBITS(NB), .AUTO_DIV(AUTO_DIV)
  ) dut (
    .clk(clk), .rst(rst), .gp_sel(gp_sel), .gp_data(gp_data),
    .gp_latch(gp_latch), .gp_clk(gp_clk), .ctrl_go(ctrl_go),
    .ctrl_auto(ctrl_auto), .ctrl_rdy(ctrl_rdy), .scan_done(scan_done),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_value(rd_value), .rd_chg(rd_chg)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pad model: raw[] are line levels, bit 0 shifted out first.
  logic [NB-1:0] raw [NPADS];
  logic [NB-1:0] sr  [NPADS];
  logic          clk_prev = 1'b1;

  always @(posedge clk) begin
    clk_prev <= gp_clk;
    for (int p = 0; p < NPADS; p++) begin
      if (gp_latch)               sr[p] <= raw[p];
      else if (!clk_prev && gp_clk) sr[p] <= {1'b1, sr[p][NB-1:1]};
    end
  end

  assign gp_data = {sr[2 * int'(gp_sel) + 1][0], sr[2 * int'(gp_sel)][0]};

  // Expected pad state and read scoreboard.
  typedef struct {
    logic [NB-1:0] v;
    logic          c;
    int            idx;
  } rd_exp_t;

  rd_exp_t       sb [$];
  rd_exp_t       sb_e;
  logic [NB-1:0] m_pad [NPADS];
  logic          m_chg [NPADS];
  logic          rd_fire = 1'b0;

  always @(posedge clk) rd_fire <= rd_en && rst;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (sb.size() == 0) check("sb_empty", 32'd0, 32'd1);
      else begin
        sb_e = sb.pop_front();
        check($sformatf("rd_value[%0d]", sb_e.idx), 32'(rd_value), 32'(sb_e.v));
        check($sformatf("rd_chg[%0d]", sb_e.idx), 32'(rd_chg), 32'(sb_e.c));
      end
    end
  end

  task automatic model_reset();
    for (int p = 0; p < NPADS; p++) begin
      m_pad[p] = '0;
      m_chg[p] = 1'b0;
    end
  endtask

  task automatic model_scan();
    logic [NB-1:0] nw;
    for (int p = 0; p < NPADS; p++) begin
      nw = ~raw[p];
      if (nw != m_pad[p]) m_chg[p] = 1'b1;
      m_pad[p] = nw;
    end
  endtask

  task automatic rd_set(input int idx);
    rd_en  = 1'b1;
    rd_idx = 2'(idx);
    sb.push_back('{v: m_pad[idx], c: m_chg[idx], idx: idx});
    m_chg[idx] = 1'b0;
  endtask

  task automatic read_all();
    for (int p = 0; p < NPADS; p++) begin
      rd_set(p);
      @(negedge clk);
      rd_en = 1'b0;
    end
    @(negedge clk);
  endtask

  int latch_cyc, lo_cyc, falls;
  bit busy_ok;

  // Runs one scan from a negedge. With go=1 the go edge is the reference, so
  // latency is edges-1; with go=0 the scan began on the previous edge.
  task automatic do_scan(input bit go, input int go_mid, input int rd_at, input int rd_pad,
                         output int lat);
    int  edges;
    logic prev;
    edges = 0; lat = -1; prev = 1'b1;
    latch_cyc = 0; lo_cyc = 0; falls = 0; busy_ok = 1'b1;
    ctrl_go = go;
    while (edges < LIMIT) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      ctrl_go = (go_mid != 0 && edges == go_mid);
      rd_en = 1'b0;
      if (rd_at != 0 && edges == rd_at) rd_set(rd_pad);
      if (rd_at != 0 && edges == rd_at + 1) check("commit_sel", 32'(gp_sel), 32'd1);
      if (gp_latch) latch_cyc++;
      if (!gp_clk) lo_cyc++;
      if (prev && !gp_clk) falls++;
      prev = gp_clk;
      if (scan_done) begin
        lat = go ? edges - 1 : edges;
        break;
      end
      if (ctrl_rdy) busy_ok = 1'b0;
    end
    ctrl_go = 1'b0;
    rd_en   = 1'b0;
  endtask

  int lat, cnt, busy_seen;

  initial begin
    ctrl_go = 0; ctrl_auto = 0; rd_en = 0; rd_idx = 0;
    raw[0] = 16'h0000; raw[1] = 16'hFFFF; raw[2] = 16'hFFFF; raw[3] = 16'h0000;
    model_reset();

    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_gp_clk",    32'(gp_clk),    32'd1);
    check("rst_gp_latch",  32'(gp_latch),  32'd0);
    check("rst_ctrl_rdy",  32'(ctrl_rdy),  32'd1);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_gp_sel",    32'(gp_sel),    32'd0);
    read_all();

    // Timing and data mapping: pad0/pad3 held pressed, pad1/pad2 released.
    do_scan(1'b1, 0, 0, 0, lat);
    check("scan_lat",    32'(lat),       32'(SCAN_LAT));
    check("latch_cyc",   32'(latch_cyc), 32'(NGRP * (DIV + 1)));
    check("clk_lo_cyc",  32'(lo_cyc),    32'(NGRP * NB * (DIV + 1)));
    check("clk_falls",   32'(falls),     32'(NGRP * NB));
    check("busy_rdy",    32'(busy_ok),   32'd1);
    @(negedge clk);
    check("done_pulse",  32'(scan_done), 32'd0);
    check("done_rdy",    32'(ctrl_rdy),  32'd1);
    model_scan();
    read_all();

    // Bit order, then an unchanged re-scan.
    raw[0] = 16'h5A3C;
    do_scan(1'b1, 0, 0, 0, lat);
    model_scan();
    read_all();
    do_scan(1'b1, 0, 0, 0, lat);
    model_scan();
    read_all();

    // Auto mode with a go pulse while busy.
    ctrl_auto = 1'b1;
    do_scan(1'b1, 300, 0, 0, lat);
    check("auto_lat",  32'(lat),     32'(SCAN_LAT));
    check("auto_busy", 32'(busy_ok), 32'd1);
    model_scan();
    // Tick counter reloads on the last CLK_HI tick, one clk before scan_done
    // is visible, so the AUTO_DIV-th idle tick lands AUTO_DIV*(DIV+1)-1 clk later.
    @(negedge clk);
    cnt = 1;
    while (ctrl_rdy && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    check("auto_gap", 32'(cnt), 32'(AUTO_DIV * (DIV + 1) - 1));
    ctrl_auto = 1'b0;
    do_scan(1'b0, 0, 0, 0, lat);
    check("auto2_lat", 32'(lat), 32'(SCAN_LAT));
    model_scan();
    busy_seen = 0;
    repeat (3 * AUTO_DIV * (DIV + 1) + 20) begin
      @(negedge clk);
      if (!ctrl_rdy) busy_seen++;
    end
    check("auto_stop", 32'(busy_seen), 32'd0);

    // Read of pad 0 in the group-0 COMMIT clk.
    raw[0] = 16'h0F0F;
    do_scan(1'b1, 0, GRP_CLK + 1, 0, lat);
    check("coll_lat", 32'(lat), 32'(SCAN_LAT));
    model_scan();
    read_all();

    // Reset during a group-1 CLK_LO.
    ctrl_go = 1'b1;
    @(negedge clk);
    ctrl_go = 1'b0;
    cnt = 0;
    while (!(gp_sel == 1'b1 && !gp_clk) && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_clk_lo", 32'(gp_clk), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_gp_clk",    32'(gp_clk),    32'd1);
    check("mrst_gp_latch",  32'(gp_latch),  32'd0);
    check("mrst_ctrl_rdy",  32'(ctrl_rdy),  32'd1);
    check("mrst_gp_sel",    32'(gp_sel),    32'd0);
    check("mrst_scan_done", 32'(scan_done), 32'd0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    read_all();
    repeat (40) @(negedge clk);
    check("mrst_stay_idle", 32'(ctrl_rdy), 32'd1);
    check("sb_drained",     32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
